// File: rtl/reg_wb_queue.sv
// Write-back sequencer: buffers ALU and load register writes in an in-order FIFO
// and retires one entry per cycle onto the register file write port.
module reg_wb_queue #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 8,
  parameter  int AW    = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int NR    = 1 << AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_reg,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_reg,
  input  logic [DW-1:0] mem_data,
  output logic          write_en,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic [NR-1:0] pending_mask,
  output logic [CW-1:0] count
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] fifo_reg  [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, off;
  logic [CW-1:0] free;
  logic          mem_push, alu_push, pop;

  // Readys look only at the occupancy at cycle start; a pop this edge gives no credit.
  always_comb begin
    free      = DEPTH_C - count;
    mem_ready = (free >= CW'(1)) && !flush && rst_n;
    alu_ready = (mem_valid ? (free >= CW'(2)) : (free >= CW'(1))) && !flush && rst_n;
    mem_push  = mem_valid && mem_ready;
    alu_push  = alu_valid && alu_ready;
    pop       = (count != '0);
  end

  // The load entry takes the older slot when both sides push together.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      fifo_reg[wr_ptr]  <= mem_reg;
      fifo_data[wr_ptr] <= mem_data;
    end
    if (alu_push) begin
      fifo_reg[wr_ptr + PW'(mem_push)]  <= alu_reg;
      fifo_data[wr_ptr + PW'(mem_push)] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      write_en   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (flush) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      write_en <= 1'b0;
    end else begin
      if (pop) begin
        write_en   <= 1'b1;
        write_reg  <= fifo_reg[rd_ptr];
        write_data <= fifo_data[rd_ptr];
        rd_ptr     <= rd_ptr + PW'(1);
      end else begin
        write_en <= 1'b0;
      end
      wr_ptr <= wr_ptr + PW'(mem_push) + PW'(alu_push);
      count  <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pending_mask = '0;
    off          = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (CW'(off) < count) pending_mask[fifo_reg[i]] = 1'b1;
    end
    if (write_en) pending_mask[write_reg] = 1'b1;
    if (!rst_n) pending_mask = '0;
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Randomized scoreboard bench for reg_wb_queue against a queue-based reference model.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int AW    = 2;

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n, flush;
  logic          alu_valid, alu_ready, mem_valid, mem_ready;
  logic [AW-1:0] alu_reg, mem_reg, write_reg;
  logic [DW-1:0] alu_data, mem_data, write_data;
  logic          write_en;
  logic [3:0]    pending_mask;
  logic [2:0]    count;

  reg_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .pending_mask(pending_mask), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queued entries, the entry on the write port, expected retire order.
  ent_t          mq[$];
  ent_t          exp_q[$];
  logic          pres_en   = 1'b0;
  logic [AW-1:0] pres_reg  = '0;
  logic [DW-1:0] pres_data = '0;
  logic [DW-1:0] rf [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_mask();
    logic [3:0] m = '0;
    if (!rst_n) return '0;
    foreach (mq[i]) m[mq[i].r] = 1'b1;
    if (pres_en) m[pres_reg] = 1'b1;
    return m;
  endfunction

  // Called at negedge with inputs already driven; checks, then applies the posedge.
  task automatic step();
    int   free;
    logic m_mr, m_ar, acc_m, acc_a;
    ent_t e;
    #1;
    free  = DEPTH - mq.size();
    m_mr  = rst_n && !flush && (free >= 1);
    m_ar  = rst_n && !flush && (mem_valid ? (free >= 2) : (free >= 1));
    acc_m = mem_valid && m_mr;
    acc_a = alu_valid && m_ar;
    chk("mem_ready", 32'(mem_ready), 32'(m_mr));
    chk("alu_ready", 32'(alu_ready), 32'(m_ar));
    chk("count", 32'(count), 32'(mq.size()));
    chk("pending_mask", 32'(pending_mask), 32'(model_mask()));
    chk("write_en", 32'(write_en), 32'(pres_en));
    chk("write_reg", 32'(write_reg), 32'(pres_reg));
    chk("write_data", 32'(write_data), 32'(pres_data));
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); exp_q.delete();
      pres_en = 1'b0; pres_reg = '0; pres_data = '0;
    end else if (flush) begin
      mq.delete(); exp_q.delete();
      pres_en = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        pres_en = 1'b1; pres_reg = e.r; pres_data = e.d;
      end else begin
        pres_en = 1'b0;
      end
      if (acc_m) begin
        e.r = mem_reg; e.d = mem_data;
        mq.push_back(e); exp_q.push_back(e);
      end
      if (acc_a) begin
        e.r = alu_reg; e.d = alu_data;
        mq.push_back(e); exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic av, input logic [1:0] ar, input logic [7:0] ad,
                       input logic mv, input logic [1:0] mr, input logic [7:0] md,
                       input logic fl, input logic rn);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    flush = fl; rst_n = rn;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
  endtask

  // Monitor: every presented write must be the oldest outstanding accepted request.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(write_reg), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("retire_reg", 32'(write_reg), 32'(e.r));
          chk("retire_data", 32'(write_data), 32'(e.d));
        end
        rf[write_reg] = write_data;
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    alu_valid = 1'b1; alu_reg = 2'd1; alu_data = 8'h77;
    mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
    @(negedge clk);
    // reset held with a pending ALU request
    drive(1'b1, 2'd1, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    idle(2);
    // single ALU write
    drive(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    idle(4);
    // simultaneous load and ALU push
    drive(1'b1, 2'd3, 8'h22, 1'b1, 2'd1, 8'h11, 1'b0, 1'b1);
    idle(4);
    // saturate with dual pushes
    for (int i = 0; i < 8; i++)
      drive(1'b1, 2'($urandom), 8'($urandom), 1'b1, 2'($urandom), 8'($urandom), 1'b0, 1'b1);
    idle(6);
    // same destination back-to-back
    drive(1'b1, 2'd0, 8'h01, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 2'd0, 8'h02, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 2'd0, 8'h03, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    idle(5);
    chk("rf_r0_last_wins", 32'(rf[0]), 32'h03);
    // flush with three queued entries, then a fresh request
    drive(1'b1, 2'd1, 8'h31, 1'b1, 2'd2, 8'h32, 1'b0, 1'b1);
    drive(1'b1, 2'd3, 8'h33, 1'b1, 2'd0, 8'h34, 1'b0, 1'b1);
    drive(1'b1, 2'd2, 8'h35, 1'b1, 2'd1, 8'h36, 1'b1, 1'b1);
    drive(1'b1, 2'd1, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    idle(4);
    chk("rf_r1_after_flush", 32'(rf[1]), 32'h5A);
    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 2) != 0), 2'($urandom), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 2'($urandom), 8'($urandom),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 39) != 0));
    idle(8);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
